// File: rtl/ground_scroller_if.sv
`default_nettype none
// ============================================================================
// Module   : ground_scroller_if
// Brief    : Scan-position / frame-control inputs and ground-state outputs
//            exchanged between the display logic and the ground scroller.
// Revision : 1.0 - initial release
// ============================================================================
interface ground_scroller_if #(
   parameter int POS_W = 9
);
   logic             frame_tick;
   logic             game_status;
   logic             restart;
   logic [8:0]       row_addr;
   logic [9:0]       col_addr;
   logic [POS_W-1:0] ground_position;
   logic [3:0]       speed;
   logic [15:0]      distance;
   logic             px;

   // Display/game side: drives scan position and frame control
   modport master (
      output frame_tick, game_status, restart, row_addr, col_addr,
      input  ground_position, speed, distance, px
   );

   // Scroller side
   modport slave (
      input  frame_tick, game_status, restart, row_addr, col_addr,
      output ground_position, speed, distance, px
   );
endinterface
`default_nettype wire

// File: rtl/ground_scroller.sv
`default_nettype none
// ============================================================================
// Module   : ground_scroller
// Brief    : Scrolling ground generator. Draws a solid ground line plus a
//            repeating textured strip, scrolls it once per frame at a speed
//            that ramps up over time, and tracks total distance scrolled.
// Revision : 1.0 - initial release
// ============================================================================
module ground_scroller #(
   parameter int                         H_RES       = 640,
   parameter int                         GROUND_ROW  = 400,
   parameter int                         GROUND_H    = 8,
   parameter int                         TILE_W      = 40,
   parameter int                         N_TILES     = 8,
   parameter logic [TILE_W*N_TILES-1:0]  PATTERN     = '0,
   parameter int                         SPEED_INIT  = 4,
   parameter int                         SPEED_MAX   = 12,
   parameter int                         RAMP_FRAMES = 256
) (
   input  wire logic          CLK,
   input  wire logic          rst,
   ground_scroller_if.slave   bus
);

   localparam int P        = TILE_W * N_TILES;
   localparam int POS_W    = (P > 1) ? $clog2(P) : 1;
   localparam int RAMP_W   = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
   // Wide enough for any 10-bit column plus any offset
   localparam int IDX_W    = $clog2(1024 + P) + 1;
   localparam int N_STAGES = (H_RES + P + P - 1) / P;

   localparam logic [POS_W:0]    P_SUM     = (POS_W+1)'(P);
   localparam logic [IDX_W-1:0]  P_IDX     = IDX_W'(P);
   localparam logic [3:0]        SPD_INIT  = 4'(SPEED_INIT);
   localparam logic [3:0]        SPD_MAX   = 4'(SPEED_MAX);
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
   localparam logic [10:0]       COL_LIM   = 11'(H_RES);
   localparam logic [9:0]        ROW_LINE  = 10'(GROUND_ROW);
   localparam logic [9:0]        ROW_END   = 10'(GROUND_ROW + GROUND_H);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [3:0]         speed_q, speed_d;
   logic [15:0]        dist_q, dist_d;
   logic [RAMP_W-1:0]  ramp_q, ramp_d;
   logic               px_q, px_d;

   logic [POS_W:0]     w_sum;
   logic [16:0]        w_dist_sum;
   logic [IDX_W-1:0]   w_idx;

   // Extra bit on both adders so wrap and saturation are detectable
   assign w_sum      = {1'b0, pos_q} + (POS_W+1)'(speed_q);
   assign w_dist_sum = {1'b0, dist_q} + 17'(speed_q);

   // Game FSM and scroll/ramp/distance update; restart overrides everything
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      speed_d = speed_q;
      dist_d  = dist_q;
      ramp_d  = ramp_q;
      if (bus.restart) begin
         state_d = ST_IDLE;
         pos_d   = '0;
         speed_d = SPD_INIT;
         dist_d  = '0;
         ramp_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.game_status) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!bus.game_status) begin
                  state_d = ST_HALT;
               end else if (bus.frame_tick) begin
                  pos_d  = (w_sum >= P_SUM) ? POS_W'(w_sum - P_SUM)
                                            : w_sum[POS_W-1:0];
                  dist_d = w_dist_sum[16] ? 16'hFFFF : w_dist_sum[15:0];
                  if (ramp_q == RAMP_LAST) begin
                     ramp_d = '0;
                     if (speed_q < SPD_MAX) speed_d = speed_q + 4'd1;
                  end else begin
                     ramp_d = ramp_q + RAMP_W'(1);
                  end
               end
            end
            ST_HALT: begin
               if (bus.game_status) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Texture index: (col + offset) mod P by repeated compare-subtract
   always_comb begin
      w_idx = IDX_W'(bus.col_addr) + IDX_W'(pos_q);
      for (int i = 0; i < N_STAGES; i++) begin
         if (w_idx >= P_IDX) w_idx = w_idx - P_IDX;
      end
   end

   // Ground pixel selection: line row, textured strip below it, else blank
   always_comb begin
      px_d = 1'b0;
      if ({1'b0, bus.col_addr} >= COL_LIM) begin
         px_d = 1'b0;
      end else if ({1'b0, bus.row_addr} == ROW_LINE) begin
         px_d = 1'b1;
      end else if (({1'b0, bus.row_addr} > ROW_LINE) &&
                   ({1'b0, bus.row_addr} < ROW_END)) begin
         px_d = (w_idx < P_IDX) ? PATTERN[w_idx[POS_W-1:0]] : 1'b0;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pos_q   <= '0;
         speed_q <= SPD_INIT;
         dist_q  <= '0;
         ramp_q  <= '0;
         px_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         speed_q <= speed_d;
         dist_q  <= dist_d;
         ramp_q  <= ramp_d;
         px_q    <= px_d;
      end
   end

   assign bus.ground_position = pos_q;
   assign bus.speed           = speed_q;
   assign bus.distance        = dist_q;
   assign bus.px              = px_q;

endmodule
`default_nettype wire
